// File: rtl/data_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_loader_pkg
// Shared definitions for the boot-time data-memory loader.
//   DATA_MEM_WIDTH / DATA_MEM_DEPTH : data-memory geometry
//   BYTES_PER_WORD                  : bytes assembled into one memory word
//   loader_state_t                  : loader FSM state encoding
// Optional feature macro used by the loader: DATA_MEM_LOADER_CHECKSUM_EN
// ---------------------------------------------------------------------------
package data_mem_loader_pkg;

  localparam int DATA_MEM_WIDTH = 4;
  localparam int DATA_MEM_DEPTH = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    SUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/data_mem_loader_if.sv
// ---------------------------------------------------------------------------
// data_mem_loader_if
// Bundles the loader's control, UART byte stream and memory write port.
//   start            : one-cycle load request
//   rx_data/rx_valid : received byte and its strobe
//   we/addr/din      : data-memory write port
//   busy/done/error  : load status for the boot controller
// Modports: master = boot environment side, slave = loader side.
// ---------------------------------------------------------------------------
interface data_mem_loader_if;
  import data_mem_loader_pkg::*;

  logic                      start;
  logic [7:0]                rx_data;
  logic                      rx_valid;
  logic                      we;
  logic [DATA_MEM_WIDTH-1:0] addr;
  logic [31:0]               din;
  logic                      busy;
  logic                      done;
  logic                      error;

  modport master (
    output start, rx_data, rx_valid,
    input  we, addr, din, busy, done, error
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output we, addr, din, busy, done, error
  );

endinterface

// File: rtl/data_mem_loader_byte_assembler.sv
// ---------------------------------------------------------------------------
// byte_assembler
// Collects bytes MSB first into a 32-bit word.
//   clk, reset     : clock, synchronous active-high reset
//   clear_i        : restart the byte count (new load)
//   byte_valid_i   : byte strobe (already gated by the loader)
//   byte_i         : incoming byte
//   word_o         : assembled word, valid together with word_valid_o
//   word_valid_o   : one-cycle pulse in the cycle the 4th byte arrives
// ---------------------------------------------------------------------------
module byte_assembler
  import data_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  // The 4th byte is spliced in combinationally so the loader can register
  // the write in the very cycle after that byte arrives; only the first
  // three bytes need storage.
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    word_o       = {shift_q, byte_i};
    word_valid_o = 1'b0;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      shift_d      = {shift_q[15:0], byte_i};
      cnt_d        = cnt_q + 2'd1;
      word_valid_o = (cnt_q == 2'(BYTES_PER_WORD - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/data_mem_loader.sv
// ---------------------------------------------------------------------------
// data_mem_loader
// Boot loader: receives "N, then N words" as a big-endian byte stream and
// writes the words to data memory from address 0 upward.
//   clk, reset : clock, synchronous active-high reset
//   bus        : data_mem_loader_if.slave (start, rx byte stream, memory
//                write port we/addr/din, status busy/done/error)
// Optional: DATA_MEM_LOADER_CHECKSUM_EN adds a 32-bit trailer holding the
// wraparound sum of the data words; a mismatch ends the load in ERR.
// ---------------------------------------------------------------------------
module data_mem_loader
  import data_mem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  data_mem_loader_if.slave bus
);

  // One extra bit so a count of DATA_MEM_DEPTH words is representable.
  localparam int CW = DATA_MEM_WIDTH + 1;

  loader_state_t             state_q, state_d;
  logic [CW-1:0]             wcnt_q, wcnt_d;
  logic [CW-1:0]             len_q, len_d;
  logic                      we_q, we_d;
  logic [DATA_MEM_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               din_q, din_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
  logic [31:0]               sum_q, sum_d;
`endif

  logic        startAccept;
  logic        byteAccept;
  logic [31:0] word;
  logic        wordValid;

  // Bytes only count while a load is in progress, and start only matters
  // once the previous load has ended.
  assign startAccept = bus.start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign byteAccept  = bus.rx_valid && (state_q == LEN || state_q == DATA || state_q == SUM);

  byte_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (startAccept),
    .byte_valid_i (byteAccept),
    .byte_i       (bus.rx_data),
    .word_o       (word),
    .word_valid_o (wordValid)
  );

  // Next-state and registered-output logic. The length test is a full
  // 32-bit compare so huge lengths cannot alias onto small ones.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (startAccept) begin
          state_d = LEN;
          wcnt_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LEN: begin
        if (wordValid) begin
          len_d = word[CW-1:0];
          if (word > 32'(DATA_MEM_DEPTH)) begin
            state_d = ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else if (word == 32'd0) begin
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
            state_d = SUM;
`else
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (wordValid) begin
          we_d   = 1'b1;
          addr_d = wcnt_q[DATA_MEM_WIDTH-1:0];
          din_d  = word;
          wcnt_d = wcnt_q + CW'(1);
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + word;
`endif
          if (wcnt_q == len_q - CW'(1)) begin
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
            state_d = SUM;
`else
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
          end
        end
      end
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
      SUM: begin
        if (wordValid) begin
          busy_d = 1'b0;
          if (word == sum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.din   = din_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.error = error_q;

endmodule

// File: tb/tb_data_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_data_mem_loader
// Self-checking bench for data_mem_loader. Expected memory writes are queued
// as the 4th byte of each data word is driven and popped by a monitor when
// the loader pulses we. Honours DATA_MEM_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_data_mem_loader;
  import data_mem_loader_pkg::*;

  typedef struct packed {
    logic [DATA_MEM_WIDTH-1:0] addr;
    logic [31:0]               data;
  } wr_t;

  logic clk;
  logic reset;

  data_mem_loader_if bus ();

  data_mem_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  wr_t         sb[$];
  logic [31:0] stim[$];
  logic [31:0] mem [DATA_MEM_DEPTH];
  int          expAddr = 0;

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every we pulse must match the oldest queued write; the
  // bench keeps its own memory image for readback checks.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      checkOutput("weExpected", 32'(bus.we), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        checkOutput("wrAddr", 32'(bus.addr), 32'(e.addr));
        checkOutput("wrData", bus.din, e.data);
      end
      mem[bus.addr] = bus.din;
    end
  end

  // Drive one byte for exactly one sampling edge; returns at edge+1.
  task automatic applyStimulus(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  // Drive a word MSB first with gap idle cycles before each byte. For data
  // words the expected write is queued and we is checked one cycle after
  // the 4th byte.
  task automatic sendWord(input logic [31:0] w, input int gap, input bit isData);
    for (int i = 3; i >= 0; i--) begin
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
      if (i == 0 && isData) begin
        sb.push_back('{addr: expAddr[DATA_MEM_WIDTH-1:0], data: w});
        expAddr++;
      end
      applyStimulus(w[8*i +: 8]);
    end
    if (isData) checkOutput("weLatency", 32'(bus.we), 32'd1);
  endtask

  // Start pulse; busy must be up and old status cleared on the next cycle.
  task automatic pulseStart();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("busyRise", 32'(bus.busy), 32'd1);
    checkOutput("doneClr", 32'(bus.done), 32'd0);
    checkOutput("errorClr", 32'(bus.error), 32'd0);
  endtask

  // Full successful load of the words in stim (plus trailer if enabled).
  task automatic runLoad(input int gap);
    logic [31:0] sum;
    sum     = '0;
    expAddr = 0;
    sendWord(32'(stim.size()), gap, 1'b0);
    foreach (stim[i]) begin
      sendWord(stim[i], gap, 1'b1);
      sum = sum + stim[i];
    end
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
    sendWord(sum, gap, 1'b0);
`endif
    checkOutput("loadDone", 32'(bus.done), 32'd1);
    checkOutput("loadBusy", 32'(bus.busy), 32'd0);
    checkOutput("loadError", 32'(bus.error), 32'd0);
  endtask

  // Main sequence of scenarios.
  initial begin
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rstWe", 32'(bus.we), 32'd0);
    checkOutput("rstAddr", 32'(bus.addr), 32'd0);
    checkOutput("rstDin", bus.din, 32'd0);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstDone", 32'(bus.done), 32'd0);
    checkOutput("rstError", 32'(bus.error), 32'd0);

    // Basic load with 3-cycle gaps.
    $display("[TB] basic load");
    pulseStart();
    stim = '{32'hDEADBEEF, 32'h01020304};
    runLoad(3);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("memRd0", mem[0], 32'hDEADBEEF);
    checkOutput("memRd1", mem[1], 32'h01020304);

    // Same stream, back-to-back bytes.
    $display("[TB] back-to-back");
    pulseStart();
    runLoad(0);

    // Oversize length, then a huge one that must not alias, then full depth.
    $display("[TB] oversize");
    pulseStart();
    sendWord(32'(DATA_MEM_DEPTH + 1), 0, 1'b0);
    checkOutput("ovfError", 32'(bus.error), 32'd1);
    checkOutput("ovfBusy", 32'(bus.busy), 32'd0);
    checkOutput("ovfDone", 32'(bus.done), 32'd0);
    pulseStart();
    sendWord(32'h0001_0000, 1, 1'b0);
    checkOutput("hugeError", 32'(bus.error), 32'd1);
    checkOutput("hugeDone", 32'(bus.done), 32'd0);
    pulseStart();
    stim.delete();
    for (int i = 0; i < DATA_MEM_DEPTH; i++) stim.push_back($urandom);
    runLoad(0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("memLast", mem[DATA_MEM_DEPTH-1], stim[DATA_MEM_DEPTH-1]);

    // Zero length, ignored bytes in DONE, then restart.
    $display("[TB] zero length and restart");
    pulseStart();
    stim.delete();
    runLoad(1);
    sendWord(32'hCAFEF00D, 0, 1'b0);
    checkOutput("doneHeld", 32'(bus.done), 32'd1);
    pulseStart();
    stim = '{32'h0A0B0C0D};
    runLoad(2);

    // Reset after one and a half data words.
    $display("[TB] reset mid-load");
    pulseStart();
    expAddr = 0;
    sendWord(32'd2, 1, 1'b0);
    sendWord(32'h55AA33CC, 1, 1'b1);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midWe", 32'(bus.we), 32'd0);
    checkOutput("midAddr", 32'(bus.addr), 32'd0);
    checkOutput("midDin", bus.din, 32'd0);
    checkOutput("midBusy", 32'(bus.busy), 32'd0);
    checkOutput("midDone", 32'(bus.done), 32'd0);
    checkOutput("midError", 32'(bus.error), 32'd0);
    checkOutput("midMem0", mem[0], 32'h55AA33CC);
    sendWord(32'h99887766, 0, 1'b0);
    checkOutput("idleBusy", 32'(bus.busy), 32'd0);
    pulseStart();
    stim = '{32'h13579BDF, 32'h2468ACE0};
    runLoad(1);

`ifdef DATA_MEM_LOADER_CHECKSUM_EN
    // Checksum wraps to zero: good trailer, then a bad one.
    $display("[TB] checksum");
    pulseStart();
    stim = '{32'h00000001, 32'hFFFFFFFF};
    runLoad(0);
    pulseStart();
    expAddr = 0;
    sendWord(32'd2, 0, 1'b0);
    sendWord(32'h00000001, 0, 1'b1);
    sendWord(32'hFFFFFFFF, 0, 1'b1);
    sendWord(32'h00000001, 0, 1'b0);
    checkOutput("sumError", 32'(bus.error), 32'd1);
    checkOutput("sumDone", 32'(bus.done), 32'd0);
    checkOutput("sumBusy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sumMem0", mem[0], 32'h00000001);
    checkOutput("sumMem1", mem[1], 32'hFFFFFFFF);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sbEmpty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
